// File: rtl/rgb_pkg.sv
// Shared widths, LED bit positions and FSM encoding for the RGB PWM driver.
package rgb_pkg;
  localparam int LED_W    = 3;
  localparam int PAT_W    = 6;
  localparam int R        = 2;
  localparam int G        = 1;
  localparam int B        = 0;
  localparam int LED0_LSB = 0;
  localparam int LED1_LSB = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: prescaler producing ticks and a CNT_W-bit period counter.
module rgb_pwm_timebase #(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             wrap
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (pre_q == PRE_W'(PRESCALE - 1));
    wrap  = tick && (cnt_q == '1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/rgb_pwm_driver.sv
// Two-LED RGB PWM driver; pattern and duty are applied only at period wrap.
// Define RGB_PWM_BREATHE_EN to replace the duty port with a triangle ramp.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       pattern_in,
  input  logic             pattern_valid,
  output logic             pattern_ready,
  input  logic [CNT_W-1:0] duty,
  output logic [2:0]       led0_rgb,
  output logic [2:0]       led1_rgb,
  output logic             period_start
);
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             tick_unused;

  rgb_pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt),
    .tick (tick_unused),
    .wrap (wrap)
  );

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pend_q, pend_d;
  logic               full_q, full_d;
  logic [PAT_W-1:0]   act_q, act_d;
  logic [CNT_W-1:0]   aduty_q, aduty_d;
  logic [LED_W-1:0]   led0_q, led0_d, led1_q, led1_d;
  logic               ps_q, ps_d;
  logic [CNT_W-1:0]   duty_src;
  logic               on;

`ifdef RGB_PWM_BREATHE_EN
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic             up_q, up_d;
  logic             duty_unused;

  // Ramp turns around by holding its end value for one extra period.
  always_comb begin
    ramp_d      = ramp_q;
    up_d        = up_q;
    duty_unused = ^duty;
    if (wrap) begin
      if (up_q) begin
        if (ramp_q == '1) up_d = 1'b0;
        else              ramp_d = ramp_q + 1'b1;
      end else begin
        if (ramp_q == '0) up_d = 1'b1;
        else              ramp_d = ramp_q - 1'b1;
      end
    end
    duty_src = ramp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_q <= '0;
      up_q   <= 1'b1;
    end else begin
      ramp_q <= ramp_d;
      up_q   <= up_d;
    end
  end
`else
  always_comb duty_src = duty;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    full_d  = full_q;
    act_d   = act_q;
    aduty_d = aduty_q;
    ps_d    = wrap;
    on      = (cnt < aduty_q);
    led0_d  = '0;
    led1_d  = '0;
    if (state_q == RUN) begin
      led0_d = act_q[LED0_LSB +: LED_W] & {LED_W{on}};
      led1_d = act_q[LED1_LSB +: LED_W] & {LED_W{on}};
    end
    if (wrap) begin
      if (full_q) begin
        act_d   = pend_q;
        full_d  = 1'b0;
        state_d = RUN;
      end
      aduty_d = duty_src;
    end
    // Not ready while full, so a wrap-time drain and an accept never coincide.
    if (pattern_valid && !full_q) begin
      pend_d = pattern_in;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      full_q  <= 1'b0;
      act_q   <= '0;
      aduty_q <= '0;
      led0_q  <= '0;
      led1_q  <= '0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      act_q   <= act_d;
      aduty_q <= aduty_d;
      led0_q  <= led0_d;
      led1_q  <= led1_d;
      ps_q    <= ps_d;
    end
  end

  assign pattern_ready = !full_q;
  assign led0_rgb      = led0_q;
  assign led1_rgb      = led1_q;
  assign period_start  = ps_q;
endmodule
